instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  ID stage of the 5-stage MIPS pipeline. Consumes out_instruction and out_pc_branch (PC+4) from the fetch stage.
//  Contains the 32x32 register file and decodes opcode/funct into control. Drives the jump/register redirect
//  back to fetch. Registers operands and control into the ID/EX pipeline register for the execute stage.
// PARAMETERS
//  len        32  datapath/instruction width
//  NB_ADDR     5  register index width (32 registers)
// PORTS
//  clk             in   1    rising-edge clock
//  reset           in   1    synchronous, active-low reset (0 = reset)
//  in_instruction  in   len  instruction from fetch
//  in_pc_branch    in   len  PC+4 from fetch
//  in_stall        in   1    load-use stall from hazard unit; insert bubble
//  in_flush        in   1    branch taken in EX; squash current ID instruction
//  in_wb_enable    in   1    write-back enable
//  in_wb_addr      in   5    write-back register index
//  in_wb_data      in   len  write-back data
//  out_pc_src      out  3    fetch mux select, combinational: 000 seq, 001 jump, 100 register
//  out_pc_jump     out  len  {in_pc_branch[31:28], instr[25:0], 2'b00}, combinational
//  out_pc_register out  len  bypassed rs value, combinational (JR/JALR target)
//  out_pc_branch   out  len  registered PC+4
//  out_reg_a/b     out  len  registered rs/rt values
//  out_sign_ext    out  len  registered immediate: sign-extended, or zero-extended for ANDI/ORI/XORI
//  out_rs/rt/rd    out  5    registered indices; rd=31 for JAL, rd=rt for I-type
//  out_opcode      out  6    registered opcode
//  out_funct       out  6    registered funct
//  out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src, out_branch, out_link  out 1  registered control
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all registered outputs and all 32 registers cleared to 0. No write-back occurs that cycle.
//  - Register file: written at posedge when in_wb_enable && in_wb_addr!=0. R0 always reads 0.
//  - Read bypass: a read of a nonzero index equal to in_wb_addr with in_wb_enable returns in_wb_data in the same cycle.
//  - Latency: 1 cycle. Instruction present at edge N is visible on ID/EX outputs after edge N.
//  - Decode:
//    - op 0x00: R-type, reg_write=1. Funct 0x08 (JR) forces reg_write=0. JALR (funct 0x09) sets link=1.
//    - op 0x08-0x0F: I-ALU, alu_src=1, reg_write=1.
//    - op 0x20-0x25: load, mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1.
//    - op 0x28-0x2B: store, mem_write=1, alu_src=1.
//    - op 0x04/0x05: branch=1.
//    - op 0x02: J.
//    - op 0x03: JAL, reg_write=1, link=1, rd=31.
//    - Unknown opcode: all control 0 (NOP).
//  - out_pc_src: 001 for J/JAL; 100 for JR/JALR; otherwise 000. Forced to 000 when in_stall or in_flush is asserted.
//  - in_stall: all control outputs are loaded with 0 (bubble); data fields are don't-care. Fetch holds the instruction.
//  - in_flush: all control outputs are loaded with 0. Flush takes priority over stall when both are asserted.
//  - Write-back and stall/flush are independent: the register file is always written.
// CONFIGURATION
//  REGFILE_DEBUG_EN defined: adds ports in_debug_addr (in 5) and out_debug_data (out len).
//    out_debug_data is a combinational, unbypassed read of the register array, for the debug UART unit.
//  REGFILE_DEBUG_EN undefined: the ports are absent and functionality is otherwise identical.
// TESTING
//  1. Reset low 2 cycles, then high -> all outputs 0; reads of R1..R31 return 0.
//  2. wb R5=0xDEADBEEF; same cycle decode ADD $3,$5,$0 -> after edge: out_reg_a=0xDEADBEEF (bypass), reg_write=1, rd=3.
//  3. wb addr 0 data 0x1234, then read R0 -> 0.
//  4. ORI $2,$1,0xFFFF -> out_sign_ext=0x0000FFFF. ADDI with 0xFFFF -> 0xFFFFFFFF, alu_src=1.
//  5. J 0x0000010 with in_pc_branch=0x40000004 -> out_pc_src=001, out_pc_jump=0x40000040.
//     Same instruction with in_flush=1 -> out_pc_src=000.
//  6. LW with in_stall=1 -> next cycle all control 0.
//     LW with stall and flush both =1 -> all control 0 and out_pc_src=000.

Source files
------------

// File: rtl/instruction_decode.sv
// ID stage: register file, opcode/funct decode, jump/register redirect to fetch, ID/EX pipeline register.
// Optional REGFILE_DEBUG_EN adds an unbypassed debug read port (in_debug_addr/out_debug_data).
module instruction_decode #(
  parameter int len     = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [len-1:0]     in_instruction,
  input  logic [len-1:0]     in_pc_branch,
  input  logic               in_stall,
  input  logic               in_flush,
  input  logic               in_wb_enable,
  input  logic [NB_ADDR-1:0] in_wb_addr,
  input  logic [len-1:0]     in_wb_data,
  output logic [2:0]         out_pc_src,
  output logic [len-1:0]     out_pc_jump,
  output logic [len-1:0]     out_pc_register,
  output logic [len-1:0]     out_pc_branch,
  output logic [len-1:0]     out_reg_a,
  output logic [len-1:0]     out_reg_b,
  output logic [len-1:0]     out_sign_ext,
  output logic [NB_ADDR-1:0] out_rs,
  output logic [NB_ADDR-1:0] out_rt,
  output logic [NB_ADDR-1:0] out_rd,
  output logic [5:0]         out_opcode,
  output logic [5:0]         out_funct,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               out_mem_to_reg,
  output logic               out_alu_src,
  output logic               out_branch,
  output logic               out_link
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [NB_ADDR-1:0] in_debug_addr,
  output logic [len-1:0]     out_debug_data
`endif
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR   = 6'h08,
    FN_JALR = 6'h09
  } funct_e;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'b000,
    PC_JUMP = 3'b001,
    PC_REG  = 3'b100
  } pc_src_e;

  logic [len-1:0]     regs [2**NB_ADDR];

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [NB_ADDR-1:0] rs;
  logic [NB_ADDR-1:0] rt;
  logic [NB_ADDR-1:0] rd_field;
  logic [15:0]        imm;

  logic [len-1:0]     rs_val;
  logic [len-1:0]     rt_val;
  logic [len-1:0]     imm_ext;
  logic [NB_ADDR-1:0] rd_sel;

  logic c_reg_write, c_mem_read, c_mem_write, c_mem_to_reg, c_alu_src, c_branch, c_link;
  logic bubble;

  assign opcode   = in_instruction[31:26];
  assign rs       = in_instruction[25:21];
  assign rt       = in_instruction[20:16];
  assign rd_field = in_instruction[15:11];
  assign funct    = in_instruction[5:0];
  assign imm      = in_instruction[15:0];
  assign bubble   = in_stall || in_flush;

  // Same-cycle write-back is forwarded so the ID stage never reads stale data.
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (rs == '0)
      rs_val = '0;
    else if (in_wb_enable && in_wb_addr == rs)
      rs_val = in_wb_data;
    if (rt == '0)
      rt_val = '0;
    else if (in_wb_enable && in_wb_addr == rt)
      rt_val = in_wb_data;
  end

  always_comb begin
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      imm_ext = {{(len-16){1'b0}}, imm};
    else
      imm_ext = {{(len-16){imm[15]}}, imm};
  end

  always_comb begin
    c_reg_write  = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 1'b0;
    c_alu_src    = 1'b0;
    c_branch     = 1'b0;
    c_link       = 1'b0;
    rd_sel       = rt;
    if (opcode == OP_RTYPE) begin
      rd_sel      = rd_field;
      c_reg_write = (funct != FN_JR);
      c_link      = (funct == FN_JALR);
    end else if (opcode inside {[6'h08:6'h0F]}) begin
      c_alu_src   = 1'b1;
      c_reg_write = 1'b1;
    end else if (opcode inside {[6'h20:6'h25]}) begin
      c_mem_read   = 1'b1;
      c_mem_to_reg = 1'b1;
      c_alu_src    = 1'b1;
      c_reg_write  = 1'b1;
    end else if (opcode inside {[6'h28:6'h2B]}) begin
      c_mem_write = 1'b1;
      c_alu_src   = 1'b1;
    end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
      c_branch = 1'b1;
    end else if (opcode == OP_JAL) begin
      c_reg_write = 1'b1;
      c_link      = 1'b1;
      rd_sel      = NB_ADDR'(31);
    end
  end

  // Fetch redirect is combinational; a bubbled instruction must not redirect.
  always_comb begin
    out_pc_src = PC_SEQ;
    if (!bubble) begin
      if (opcode == OP_J || opcode == OP_JAL)
        out_pc_src = PC_JUMP;
      else if (opcode == OP_RTYPE && (funct == FN_JR || funct == FN_JALR))
        out_pc_src = PC_REG;
    end
  end

  assign out_pc_jump     = {in_pc_branch[len-1:len-4], in_instruction[25:0], 2'b00};
  assign out_pc_register = rs_val;

  always_ff @(posedge clk) begin
    if (!reset)
      regs <= '{default: '0};
    else if (in_wb_enable && in_wb_addr != '0)
      regs[in_wb_addr] <= in_wb_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_pc_branch  <= '0;
      out_reg_a      <= '0;
      out_reg_b      <= '0;
      out_sign_ext   <= '0;
      out_rs         <= '0;
      out_rt         <= '0;
      out_rd         <= '0;
      out_opcode     <= '0;
      out_funct      <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_alu_src    <= 1'b0;
      out_branch     <= 1'b0;
      out_link       <= 1'b0;
    end else begin
      out_pc_branch  <= in_pc_branch;
      out_reg_a      <= rs_val;
      out_reg_b      <= rt_val;
      out_sign_ext   <= imm_ext;
      out_rs         <= rs;
      out_rt         <= rt;
      out_rd         <= rd_sel;
      out_opcode     <= opcode;
      out_funct      <= funct;
      out_reg_write  <= c_reg_write  && !bubble;
      out_mem_read   <= c_mem_read   && !bubble;
      out_mem_write  <= c_mem_write  && !bubble;
      out_mem_to_reg <= c_mem_to_reg && !bubble;
      out_alu_src    <= c_alu_src    && !bubble;
      out_branch     <= c_branch     && !bubble;
      out_link       <= c_link       && !bubble;
    end
  end

`ifdef REGFILE_DEBUG_EN
  assign out_debug_data = regs[in_debug_addr];
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed literal checks, then random stimulus against a behavioural model.
module tb_instruction_decode;

  logic        clk;
  logic        reset;
  logic [31:0] in_instruction;
  logic [31:0] in_pc_branch;
  logic        in_stall;
  logic        in_flush;
  logic        in_wb_enable;
  logic [4:0]  in_wb_addr;
  logic [31:0] in_wb_data;
  logic [2:0]  out_pc_src;
  logic [31:0] out_pc_jump;
  logic [31:0] out_pc_register;
  logic [31:0] out_pc_branch;
  logic [31:0] out_reg_a;
  logic [31:0] out_reg_b;
  logic [31:0] out_sign_ext;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
  logic        out_alu_src, out_branch, out_link;
`ifdef REGFILE_DEBUG_EN
  logic [4:0]  in_debug_addr;
  logic [31:0] out_debug_data;
  assign in_debug_addr = 5'd0;
`endif

  instruction_decode #(.len(32), .NB_ADDR(5)) dut (
    .clk(clk), .reset(reset),
    .in_instruction(in_instruction), .in_pc_branch(in_pc_branch),
    .in_stall(in_stall), .in_flush(in_flush),
    .in_wb_enable(in_wb_enable), .in_wb_addr(in_wb_addr), .in_wb_data(in_wb_data),
    .out_pc_src(out_pc_src), .out_pc_jump(out_pc_jump), .out_pc_register(out_pc_register),
    .out_pc_branch(out_pc_branch), .out_reg_a(out_reg_a), .out_reg_b(out_reg_b),
    .out_sign_ext(out_sign_ext), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct(out_funct),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_alu_src(out_alu_src), .out_branch(out_branch),
    .out_link(out_link)
`ifdef REGFILE_DEBUG_EN
    , .in_debug_addr(in_debug_addr), .out_debug_data(out_debug_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ctrl packing: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, link}
  typedef struct packed {
    logic [31:0] pc_branch, reg_a, reg_b, sign_ext;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  opcode, funct;
    logic [6:0]  ctrl;
  } idex_t;

  logic [31:0] model_regs [32];
  idex_t       exp_q;
  logic        exp_valid  = 1'b0;
  logic        exp_bubble = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (in_wb_enable && in_wb_addr == idx) return in_wb_data;
    return model_regs[idx];
  endfunction

  function automatic logic [6:0] m_ctrl(input int op, input int fn);
    if (op == 0)                 return {fn != 8, 5'b00000, fn == 9};
    if (op >= 8 && op <= 15)     return 7'b1000100;
    if (op >= 32 && op <= 37)    return 7'b1101100;
    if (op >= 40 && op <= 43)    return 7'b0010100;
    if (op == 4 || op == 5)      return 7'b0000010;
    if (op == 3)                 return 7'b1000001;
    return 7'b0000000;
  endfunction

  function automatic logic [2:0] m_pc_src();
    int op, fn;
    op = int'(in_instruction >> 26);
    fn = int'(in_instruction & 32'h3F);
    if (in_stall || in_flush) return 3'd0;
    if (op == 2 || op == 3) return 3'd1;
    if (op == 0 && (fn == 8 || fn == 9)) return 3'd4;
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    idex_t e;
    int op, fn, imm;
    e = '0;
    if (!reset) begin
      model_regs = '{default: 32'd0};
      exp_bubble = 1'b0;
    end else begin
      op  = int'(in_instruction >> 26);
      fn  = int'(in_instruction & 32'h3F);
      imm = int'(in_instruction & 32'hFFFF);
      e.pc_branch = in_pc_branch;
      e.rs        = in_instruction[25:21];
      e.rt        = in_instruction[20:16];
      e.reg_a     = m_read(e.rs);
      e.reg_b     = m_read(e.rt);
      e.opcode    = 6'(op);
      e.funct     = 6'(fn);
      if (op >= 12 && op <= 14 || imm < 32'h8000) e.sign_ext = 32'(imm);
      else                                        e.sign_ext = 32'(imm) + 32'hFFFF0000;
      if (op == 0)      e.rd = in_instruction[15:11];
      else if (op == 3) e.rd = 5'd31;
      else              e.rd = e.rt;
      exp_bubble = in_stall || in_flush;
      e.ctrl = exp_bubble ? 7'd0 : m_ctrl(op, fn);
      if (in_wb_enable && in_wb_addr != 0) model_regs[in_wb_addr] = in_wb_data;
    end
    exp_q     = e;
    exp_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("ctrl", 32'({out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                       out_alu_src, out_branch, out_link}), 32'(exp_q.ctrl));
      if (!exp_bubble) begin
        chk("pc_branch", out_pc_branch, exp_q.pc_branch);
        chk("reg_a", out_reg_a, exp_q.reg_a);
        chk("reg_b", out_reg_b, exp_q.reg_b);
        chk("sign_ext", out_sign_ext, exp_q.sign_ext);
        chk("rs", 32'(out_rs), 32'(exp_q.rs));
        chk("rt", 32'(out_rt), 32'(exp_q.rt));
        chk("rd", 32'(out_rd), 32'(exp_q.rd));
        chk("opcode", 32'(out_opcode), 32'(exp_q.opcode));
        chk("funct", 32'(out_funct), 32'(exp_q.funct));
      end
      chk("pc_src", 32'(out_pc_src), 32'(m_pc_src()));
      chk("pc_jump", out_pc_jump, (in_pc_branch & 32'hF0000000) | ((in_instruction & 32'h03FFFFFF) << 2));
      chk("pc_register", out_pc_register, m_read(in_instruction[25:21]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
    return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(imm) & 32'hFFFF);
  endfunction

  int ops [21] = '{0, 0, 0, 2, 3, 4, 5, 8, 9, 12, 13, 14, 15, 32, 35, 37, 40, 43, 1, 63, 16};
  int fns [6]  = '{32, 34, 8, 9, 42, 0};

  initial begin
    reset = 1'b0; in_instruction = '0; in_pc_branch = '0; in_stall = 1'b0; in_flush = 1'b0;
    in_wb_enable = 1'b0; in_wb_addr = '0; in_wb_data = '0;
    tick();
    tick();
    chk("rst_reg_a", out_reg_a, 32'd0);
    chk("rst_pc_branch", out_pc_branch, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_reg_write", 32'(out_reg_write), 32'd0);
    reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      in_instruction = r_type(i, 0, 1, 32);
      #1;
      chk("rst_regfile", out_pc_register, 32'd0);
    end

    in_wb_enable = 1'b1; in_wb_addr = 5'd5; in_wb_data = 32'hDEADBEEF;
    in_instruction = r_type(5, 0, 3, 32);
    tick();
    chk("bypass_reg_a", out_reg_a, 32'hDEADBEEF);
    chk("add_reg_write", 32'(out_reg_write), 32'd1);
    chk("add_rd", 32'(out_rd), 32'd3);

    in_wb_addr = 5'd0; in_wb_data = 32'h1234;
    in_instruction = r_type(0, 0, 1, 32);
    tick();
    chk("r0_same_cycle", out_reg_a, 32'd0);
    in_wb_enable = 1'b0;
    tick();
    chk("r0_read", out_reg_a, 32'd0);

    in_instruction = 32'h3422FFFF;
    tick();
    chk("ori_zext", out_sign_ext, 32'h0000FFFF);
    chk("ori_rd", 32'(out_rd), 32'd2);
    in_instruction = 32'h2022FFFF;
    tick();
    chk("addi_sext", out_sign_ext, 32'hFFFFFFFF);
    chk("addi_alu_src", 32'(out_alu_src), 32'd1);

    in_instruction = 32'h08000010; in_pc_branch = 32'h40000004;
    #1;
    chk("j_pc_src", 32'(out_pc_src), 32'd1);
    chk("j_pc_jump", out_pc_jump, 32'h40000040);
    in_flush = 1'b1;
    #1;
    chk("j_flush_pc_src", 32'(out_pc_src), 32'd0);
    tick();
    in_flush = 1'b0;

    in_instruction = 32'h8C240000; in_stall = 1'b1;
    tick();
    chk("lw_stall_ctrl", 32'({out_reg_write, out_mem_read, out_mem_to_reg, out_alu_src}), 32'd0);
    in_stall = 1'b0;
    tick();
    chk("lw_ctrl", 32'({out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                        out_alu_src, out_branch, out_link}), 32'b1101100);
    in_stall = 1'b1; in_flush = 1'b1;
    #1;
    chk("lw_both_pc_src", 32'(out_pc_src), 32'd0);
    tick();
    chk("lw_both_ctrl", 32'({out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                             out_alu_src, out_branch, out_link}), 32'd0);
    in_stall = 1'b0; in_flush = 1'b0;

    in_instruction = r_type(5, 0, 0, 8);
    #1;
    chk("jr_pc_src", 32'(out_pc_src), 32'd4);
    chk("jr_target", out_pc_register, 32'hDEADBEEF);
    tick();
    chk("jr_reg_write", 32'(out_reg_write), 32'd0);

    for (int n = 0; n < 600; n++) begin
      int op, fn;
      reset        = ($urandom_range(0, 49) != 0);
      in_stall     = ($urandom_range(0, 7) == 0);
      in_flush     = ($urandom_range(0, 7) == 0);
      in_wb_enable = $urandom_range(0, 1) != 0;
      in_wb_addr   = 5'($urandom_range(0, 31));
      in_wb_data   = $urandom;
      in_pc_branch = $urandom;
      op = ops[$urandom_range(0, 20)];
      fn = fns[$urandom_range(0, 5)];
      in_instruction = $urandom;
      in_instruction[31:26] = 6'(op);
      if (op == 0 && fn != 0) in_instruction[5:0] = 6'(fn);
      if ($urandom_range(0, 3) == 0) in_instruction[25:21] = in_wb_addr;
      if ($urandom_range(0, 3) == 0) in_instruction[20:16] = in_wb_addr;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
